clause_prog_ctrl: RTL and testbench
===================================

# clause_prog_ctrl

Programming sequencer for a bank of clause columns in the SAT solver array. It accepts clause descriptors over a valid/ready interface: one column index, two variable indices, two literal signs and an SI bit per descriptor. For each descriptor it drives the shared word-line and bit-line programming bus of the addressed column with a fixed multi-cycle write sequence. It also owns the global SRAM_STATE (programming-mode) signal, so clause columns only accept writes while this block holds programming mode.

## Interface
Parameters:
- NCOL, 16, number of clause columns on the shared programming bus
- CW, 4, width of the column index; CW ≥ clog2(NCOL)
- NV, 60, variable rows per column (fixed, matches column WL_SW width)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- PROG_MODE  in  1  host request for programming mode
- CMD_VALID  in  1  descriptor valid
- CMD_READY  out  1  descriptor accepted on an edge where VALID&READY
- CMD_COL  in  CW  target column
- CMD_VL / CMD_VR  in  6  left/right variable index (0..NV-1)
- CMD_SL / CMD_SR  in  1  left/right literal sign
- CMD_SI  in  1  clause SI bit
- WL_SW  out  NV  per-row enable word lines
- WL_SIGN  out  1  sign-register word line
- BL_EN  out  NCOL  one-hot column select
- BL_SI / BL_SL / BL_SR  out  1  bit-line data
- SRAM_STATE  out  1  programming mode; broadcast to all columns
- BUSY  out  1  sequence in progress (state ≠ IDLE)
- ERR  out  1  one-cycle pulse for a rejected descriptor
- PROG_CNT  out  16  count of clauses programmed

## Operation
- Controller states: IDLE, CLR, WRL, WRR, SGN. Outputs are Moore, decoded from registered state and captured descriptor. Each is held stable for the whole state cycle, and the column samples it on the edge that leaves the state.
- Descriptor fields are registered on accept; CMD_* inputs are don't-care afterwards.
- CMD_READY = (state==IDLE) & SRAM_STATE.
- Validation on accept: CMD_VL ≥ NV, CMD_VR ≥ NV or CMD_COL ≥ NCOL rejects the descriptor. On reject: ERR pulses high the next cycle, state stays IDLE, no bus activity, PROG_CNT unchanged.
- IDLE: WL_SW=0, WL_SIGN=0, BL_EN=0, BL_SI/SL/SR=0.
- BL_EN = onehot(COL) in CLR, WRL, WRR and SGN.
- CLR: WL_SW=all ones, BL_SL=0, BL_SR=0. Clears every row enable in the column.
- WRL: WL_SW=onehot(VL), BL_SL=1, BL_SR=(VL==VR).
- WRR: WL_SW=onehot(VR), BL_SL=0, BL_SR=1. Skipped when VL==VR, so WRL goes directly to SGN.
- SGN: WL_SW=0, WL_SIGN=1, BL_SI=SI, BL_SL=SL, BL_SR=SR.
- Transitions:
  - IDLE→CLR on a valid accept
  - CLR→WRL
  - WRL→WRR, or WRL→SGN when VL==VR
  - WRR→SGN
  - SGN→IDLE
- PROG_CNT increments on the SGN→IDLE edge and saturates at 0xFFFF. Cleared only by reset.
- SRAM_STATE follows PROG_MODE with one register stage, but updates only while state==IDLE. A PROG_MODE drop mid-sequence is deferred until the sequence returns to IDLE.

## Timing
- Reset values:
  - state IDLE
  - all bus outputs 0
  - SRAM_STATE 0, so CMD_READY is 0
  - BUSY 0, ERR 0, PROG_CNT 0
- Accept on edge E0 gives column writes on E1 (CLR), E2 (WRL), E3 (WRR) and E4 (SGN). CMD_READY returns high the cycle after E4, so the earliest next accept is E5.
- VL==VR: writes on E1..E3; next accept at E4.
- PROG_MODE rising at edge P gives SRAM_STATE high after P+1; earliest accept at P+2.
- Reset asserted mid-sequence aborts immediately. Outputs go to 0 asynchronously, and the partially written column is left as-is; the host re-issues the descriptor.
- Descriptor held with VALID while READY=0 is not lost. It is accepted on the first edge with READY=1.

## Test plan
- Reset, then PROG_MODE=1 → SRAM_STATE=1 after 2 edges and CMD_READY=1. Before that, all outputs are 0 and PROG_CNT=0.
- Descriptor COL=3, VL=5, VR=42, SL=1, SR=0, SI=1 → 4 bus cycles with BL_EN=0x0008:
  - cycle 1: WL_SW all ones, SL=SR=0
  - cycle 2: WL_SW bit5, SL=1, SR=0
  - cycle 3: WL_SW bit42, SL=0, SR=1
  - cycle 4: WL_SIGN=1, SI=1, SL=1, SR=0
  - then PROG_CNT=1, READY=1
- Descriptor VL=VR=17 → 3 bus cycles; the WRL cycle shows WL_SW bit17 with SL=SR=1, and WRR is absent.
- Descriptor VL=60 or COL=NCOL → ERR pulse for exactly 1 cycle, BL_EN stays 0, PROG_CNT unchanged, READY stays 1.
- PROG_MODE dropped during WRL → sequence completes through SGN, then SRAM_STATE falls 1 cycle later and READY=0.
- RESET_N low during WRR → all outputs 0 immediately, BUSY=0, SRAM_STATE=0, PROG_CNT=0.

Source files
------------

// File: rtl/clause_prog_ctrl_if.sv
// Clause descriptor handshake between a host and clause_prog_ctrl.
//   valid/ready : descriptor transfer on an edge where both are high
//   col         : target clause column
//   vl / vr     : left/right variable index
//   sl / sr     : left/right literal sign
//   si          : clause SI bit
interface clause_prog_ctrl_if #(
    parameter int unsigned CW = 4
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] col;
    logic [5:0]    vl;
    logic [5:0]    vr;
    logic          sl;
    logic          sr;
    logic          si;

    modport master (output valid, col, vl, vr, sl, sr, si, input ready);
    modport slave  (input valid, col, vl, vr, sl, sr, si, output ready);
endinterface

// File: rtl/clause_prog_ctrl.sv
// Programming sequencer for a bank of clause columns. Each accepted descriptor
// drives the addressed column through CLR, WRL, (WRR), SGN on the shared bus.
// The block also owns the global programming-mode signal.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   prog_mode_i    : host request for programming mode
//   cmd_if         : descriptor handshake (slave side)
//   wl_sw_o        : per-row word-line enables
//   wl_sign_o      : sign-register word line
//   bl_en_o        : one-hot column select
//   bl_si/sl/sr_o  : bit-line data
//   sram_state_o   : programming mode broadcast
//   busy_o         : sequence in progress
//   err_o          : one-cycle pulse on a rejected descriptor
//   prog_cnt_o     : saturating count of programmed clauses
module clause_prog_ctrl #(
    parameter int unsigned NCOL = 16,
    parameter int unsigned CW   = 4,
    parameter int unsigned NV   = 60
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                prog_mode_i,
    clause_prog_ctrl_if.slave   cmd_if,
    output logic [NV-1:0]       wl_sw_o,
    output logic                wl_sign_o,
    output logic [NCOL-1:0]     bl_en_o,
    output logic                bl_si_o,
    output logic                bl_sl_o,
    output logic                bl_sr_o,
    output logic                sram_state_o,
    output logic                busy_o,
    output logic                err_o,
    output logic [15:0]         prog_cnt_o
);

    typedef enum logic [2:0] {StIdle, StClr, StWrl, StWrr, StSgn} state_e;

    localparam logic [6:0]  NvLim   = NV[6:0];
    localparam logic [CW:0] NcolLim = NCOL[CW:0];

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [5:0]    vl_q;
    logic [5:0]    vr_q;
    logic          sl_q;
    logic          sr_q;
    logic          si_q;
    logic          sram_q;
    logic          err_q;
    logic [15:0]   cnt_q;

    logic accept;
    logic bad_cmd;

    assign cmd_if.ready = (state_q == StIdle) & sram_q;
    assign accept       = cmd_if.valid & cmd_if.ready;
    assign bad_cmd      = ({1'b0, cmd_if.vl} >= NvLim) | ({1'b0, cmd_if.vr} >= NvLim) |
                          ({1'b0, cmd_if.col} >= NcolLim);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            col_q   <= '0;
            vl_q    <= '0;
            vr_q    <= '0;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
            si_q    <= 1'b0;
            sram_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Mode changes only take effect between sequences.
                    sram_q <= prog_mode_i;
                    if (accept) begin
                        if (bad_cmd) begin
                            err_q <= 1'b1;
                        end else begin
                            col_q   <= cmd_if.col;
                            vl_q    <= cmd_if.vl;
                            vr_q    <= cmd_if.vr;
                            sl_q    <= cmd_if.sl;
                            sr_q    <= cmd_if.sr;
                            si_q    <= cmd_if.si;
                            state_q <= StClr;
                        end
                    end
                end
                StClr: state_q <= StWrl;
                // Both literals on one row are written together in WRL.
                StWrl: state_q <= (vl_q == vr_q) ? StSgn : StWrr;
                StWrr: state_q <= StSgn;
                StSgn: begin
                    state_q <= StIdle;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        wl_sw_o   = '0;
        wl_sign_o = 1'b0;
        bl_en_o   = '0;
        bl_si_o   = 1'b0;
        bl_sl_o   = 1'b0;
        bl_sr_o   = 1'b0;
        unique case (state_q)
            StIdle: ;
            StClr: begin
                bl_en_o = {{(NCOL-1){1'b0}}, 1'b1} << col_q;
                wl_sw_o = '1;
            end
            StWrl: begin
                bl_en_o = {{(NCOL-1){1'b0}}, 1'b1} << col_q;
                wl_sw_o = {{(NV-1){1'b0}}, 1'b1} << vl_q;
                bl_sl_o = 1'b1;
                bl_sr_o = (vl_q == vr_q);
            end
            StWrr: begin
                bl_en_o = {{(NCOL-1){1'b0}}, 1'b1} << col_q;
                wl_sw_o = {{(NV-1){1'b0}}, 1'b1} << vr_q;
                bl_sr_o = 1'b1;
            end
            StSgn: begin
                bl_en_o   = {{(NCOL-1){1'b0}}, 1'b1} << col_q;
                wl_sign_o = 1'b1;
                bl_si_o   = si_q;
                bl_sl_o   = sl_q;
                bl_sr_o   = sr_q;
            end
            default: ;
        endcase
    end

    assign sram_state_o = sram_q;
    assign busy_o       = (state_q != StIdle);
    assign err_o        = err_q;
    assign prog_cnt_o   = cnt_q;

endmodule

// File: tb/tb_clause_prog_ctrl.sv
module tb_clause_prog_ctrl;

    localparam int unsigned NCOL = 12;
    localparam int unsigned CW   = 4;
    localparam int unsigned NV   = 60;

    typedef struct {
        logic [NV-1:0]   wl;
        logic            wsign;
        logic [NCOL-1:0] en;
        logic            si;
        logic            sl;
        logic            sr;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            prog_mode;
    logic [NV-1:0]   wl_sw;
    logic            wl_sign;
    logic [NCOL-1:0] bl_en;
    logic            bl_si;
    logic            bl_sl;
    logic            bl_sr;
    logic            sram_state;
    logic            busy;
    logic            err;
    logic [15:0]     prog_cnt;

    int          checks;
    int          failures;
    logic [15:0] model_cnt;
    exp_t        sb[$];

    clause_prog_ctrl_if #(.CW(CW)) cmd ();

    clause_prog_ctrl #(.NCOL(NCOL), .CW(CW), .NV(NV)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .prog_mode_i  (prog_mode),
        .cmd_if       (cmd),
        .wl_sw_o      (wl_sw),
        .wl_sign_o    (wl_sign),
        .bl_en_o      (bl_en),
        .bl_si_o      (bl_si),
        .bl_sl_o      (bl_sl),
        .bl_sr_o      (bl_sr),
        .sram_state_o (sram_state),
        .busy_o       (busy),
        .err_o        (err),
        .prog_cnt_o   (prog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wl_sw"}, 64'(wl_sw), 64'd0);
        check({tag, "_wl_sign"}, 64'(wl_sign), 64'd0);
        check({tag, "_bl_en"}, 64'(bl_en), 64'd0);
        check({tag, "_bl_data"}, 64'({bl_si, bl_sl, bl_sr}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic push(input logic [NV-1:0] wl, input logic ws, input logic [NCOL-1:0] en,
                        input logic si, input logic sl, input logic sr);
        exp_t e;
        e.wl = wl; e.wsign = ws; e.en = en; e.si = si; e.sl = sl; e.sr = sr;
        sb.push_back(e);
    endtask

    // drop_idx/rst_idx select the bus cycle after which PROG_MODE drops or reset hits.
    task automatic send(input logic [CW-1:0] col, input logic [5:0] vl, input logic [5:0] vr,
                        input logic sl, input logic sr, input logic si,
                        input int drop_idx, input int rst_idx);
        logic [NV-1:0]   one_vl;
        logic [NV-1:0]   one_vr;
        logic [NCOL-1:0] one_col;
        exp_t            e;
        bit              ok;
        int              n;
        ok = (vl < 6'(NV)) && (vr < 6'(NV)) && (col < CW'(NCOL));
        @(negedge clk);
        cmd.valid = 1'b1; cmd.col = col; cmd.vl = vl; cmd.vr = vr;
        cmd.sl = sl; cmd.sr = sr; cmd.si = si;
        n = 0;
        while (cmd.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(cmd.ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble the inputs to show the descriptor was captured.
        cmd.valid = 1'b0; cmd.col = ~col; cmd.vl = ~vl; cmd.vr = ~vr;
        cmd.sl = ~sl; cmd.sr = ~sr; cmd.si = ~si;
        if (!ok) begin
            @(negedge clk);
            check("rej_err_hi", 64'(err), 64'd1);
            check_quiet("rej");
            @(negedge clk);
            check("rej_err_lo", 64'(err), 64'd0);
            check("rej_ready", 64'(cmd.ready), 64'd1);
            check("rej_cnt", 64'(prog_cnt), 64'(model_cnt));
            check("rej_bl_en", 64'(bl_en), 64'd0);
            return;
        end
        one_vl  = '0; one_vl[vl]   = 1'b1;
        one_vr  = '0; one_vr[vr]   = 1'b1;
        one_col = '0; one_col[col] = 1'b1;
        push('1, 1'b0, one_col, 1'b0, 1'b0, 1'b0);
        push(one_vl, 1'b0, one_col, 1'b0, 1'b1, (vl == vr));
        if (vl != vr) push(one_vr, 1'b0, one_col, 1'b0, 1'b0, 1'b1);
        push('0, 1'b1, one_col, si, sl, sr);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("cyc%0d_wl_sw", i), 64'(wl_sw), 64'(e.wl));
            check($sformatf("cyc%0d_wl_sign", i), 64'(wl_sign), 64'(e.wsign));
            check($sformatf("cyc%0d_bl_en", i), 64'(bl_en), 64'(e.en));
            check($sformatf("cyc%0d_si_sl_sr", i), 64'({bl_si, bl_sl, bl_sr}),
                  64'({e.si, e.sl, e.sr}));
            check($sformatf("cyc%0d_busy", i), 64'(busy), 64'd1);
            check($sformatf("cyc%0d_ready", i), 64'(cmd.ready), 64'd0);
            if (i == drop_idx) prog_mode = 1'b0;
            if (i == rst_idx) begin
                #1 rst_n = 1'b0;
                #1;
                model_cnt = '0;
                check_quiet("rst_mid");
                check("rst_mid_sram", 64'(sram_state), 64'd0);
                check("rst_mid_cnt", 64'(prog_cnt), 64'd0);
                check("rst_mid_ready", 64'(cmd.ready), 64'd0);
                sb.delete();
                return;
            end
        end
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        @(negedge clk);
        check_quiet("post");
        check("post_cnt", 64'(prog_cnt), 64'(model_cnt));
        check("post_ready", 64'(cmd.ready), 64'(sram_state));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_cnt = '0;
        rst_n = 1'b0;
        prog_mode = 1'b0;
        cmd.valid = 1'b0; cmd.col = '0; cmd.vl = '0; cmd.vr = '0;
        cmd.sl = 1'b0; cmd.sr = 1'b0; cmd.si = 1'b0;
        #2;
        check_quiet("rst");
        check("rst_sram", 64'(sram_state), 64'd0);
        check("rst_ready", 64'(cmd.ready), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(prog_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sram", 64'(sram_state), 64'd0);
        check("idle_ready", 64'(cmd.ready), 64'd0);

        // Enter programming mode.
        prog_mode = 1'b1;
        #1 check("pm_sram_before_edge", 64'(sram_state), 64'd0);
        @(negedge clk);
        check("pm_sram", 64'(sram_state), 64'd1);
        check("pm_ready", 64'(cmd.ready), 64'd1);
        check_quiet("pm");

        // Full four-cycle sequence.
        send(4'd3, 6'd5, 6'd42, 1'b1, 1'b0, 1'b1, -1, -1);
        // Shared row: WRR skipped.
        send(4'd5, 6'd17, 6'd17, 1'b0, 1'b1, 1'b0, -1, -1);
        // Rejections at each limit.
        send(4'd2, 6'd60, 6'd1, 1'b0, 1'b0, 1'b0, -1, -1);
        send(4'd2, 6'd1, 6'd63, 1'b0, 1'b0, 1'b0, -1, -1);
        send(4'(NCOL), 6'd1, 6'd2, 1'b0, 1'b0, 1'b0, -1, -1);
        // Highest legal indices.
        send(4'(NCOL - 1), 6'd59, 6'd0, 1'b1, 1'b1, 1'b1, -1, -1);

        // Mode drop during WRL completes the sequence, then mode falls.
        send(4'd1, 6'd8, 6'd9, 1'b0, 1'b1, 1'b1, 1, -1);
        check("drop_sram_deferred", 64'(sram_state), 64'd1);
        @(negedge clk);
        check("drop_sram_low", 64'(sram_state), 64'd0);
        check("drop_ready_low", 64'(cmd.ready), 64'd0);

        // Descriptor held while not ready is accepted once mode returns.
        fork
            send(4'd7, 6'd0, 6'd59, 1'b0, 1'b1, 1'b0, -1, -1);
            begin
                repeat (3) @(negedge clk);
                check("held_not_busy", 64'(busy), 64'd0);
                check("held_cnt", 64'(prog_cnt), 64'(model_cnt));
                prog_mode = 1'b1;
            end
        join

        // Reset during WRR aborts the sequence.
        send(4'd4, 6'd10, 6'd20, 1'b1, 1'b0, 1'b1, -1, 2);
        @(negedge clk);
        check_quiet("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_cnt", 64'(prog_cnt), 64'd0);
        check("after_rst_sram", 64'(sram_state), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
